cuenta_bits: RTL and testbench

Parametrised sequential bit counter, the N-bit successor of the 3-bit ones counter used in the practice datapath. It loads an N-bit operand on `start` and counts its ones or zeros by shift-and-accumulate, one bit per clock. It reports the result on `Cuenta` with a `fin` flag. Added over the 3-bit version: width parameter, zero-count mode, optional early termination, busy output and asynchronous reset.

---
 rtl/cuenta_bits.sv | 116 +++++++++++
 tb/tb_cuenta_bits.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cuenta_bits.sv
// -----------------------------------------------------------------------------
// cuenta_bits
// Sequential bit counter. On an accepted start it loads an N-bit operand
// (optionally inverted so that zeros are counted) into a shift register and
// accumulates one bit per clock, LSB first, into Cuenta. fin flags a valid
// result and stays high until the next start; ocupado is high while shifting.
//
// Parameters:
//   N      operand width (>= 1)
//   EARLY  1 = stop as soon as no ones remain in the shift register
//          0 = always shift N times (data-independent latency)
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   Valor    in   operand, sampled only on the edge that accepts start
//   start    in   request, level-sampled in REPOSO and DONE
//   modo     in   sampled with Valor: 0 = count ones, 1 = count zeros
//   Cuenta   out  accumulated count, valid while fin = 1
//   fin      out  result valid (state DONE)
//   ocupado  out  operation in progress (state SHIFT)
// -----------------------------------------------------------------------------
module cuenta_bits #(
   parameter int N     = 8,
   parameter bit EARLY = 1'b0,
   localparam int CW   = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  Valor,
   input  logic          start,
   input  logic          modo,
   output logic [CW-1:0] Cuenta,
   output logic          fin,
   output logic          ocupado
);

   // Index counter needs at least one bit, even for N = 1.
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   typedef enum logic [1:0] {
      REPOSO = 2'd0,
      SHIFT  = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  q_q, q_d;
   logic [CW-1:0] a_q, a_d;
   logic [KW-1:0] k_q, k_d;
   logic          fin_q, ocupado_q;
   logic          last_s;

   // Next-state and datapath update for the shift-and-accumulate FSM.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      a_d     = a_q;
      k_d     = k_q;
      // Last shift either after N bits or, in early mode, once the bits still
      // to be examined are all zero (they could not change the count).
      last_s  = (k_q == K_LAST) || (EARLY && ((q_q >> 1) == '0));

      case (state_q)
         REPOSO, DONE: begin
            if (start) begin
               q_d     = modo ? ~Valor : Valor;
               a_d     = '0;
               k_d     = '0;
               state_d = SHIFT;
            end else begin
               state_d = state_q;
            end
         end
         SHIFT: begin
            a_d = a_q + CW'(q_q[0]);
            q_d = q_q >> 1;
            k_d = k_q + KW'(1);
            if (last_s) begin
               state_d = DONE;
            end else begin
               state_d = SHIFT;
            end
         end
         default: begin
            state_d = REPOSO;
         end
      endcase
   end

   // State, datapath and registered status flags (decoded from next state so
   // they match the state register cycle for cycle).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= REPOSO;
         q_q       <= '0;
         a_q       <= '0;
         k_q       <= '0;
         fin_q     <= 1'b0;
         ocupado_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         q_q       <= q_d;
         a_q       <= a_d;
         k_q       <= k_d;
         fin_q     <= (state_d == DONE);
         ocupado_q <= (state_d == SHIFT);
      end
   end

   assign Cuenta  = a_q;
   assign fin     = fin_q;
   assign ocupado = ocupado_q;

endmodule

// File: tb/tb_cuenta_bits.sv
// -----------------------------------------------------------------------------
// tb_cuenta_bits
// Three instances: N=8/EARLY=0, N=8/EARLY=1, N=3/EARLY=0. Stimulus pushes the
// expected (instance, count, shift cycles) into a scoreboard; a monitor pops
// and compares on every rising edge of fin of any instance.
// -----------------------------------------------------------------------------
module tb_cuenta_bits;

   logic clk = 1'b0;
   logic reset = 1'b0;

   logic [7:0] v0 = 8'h00, v1 = 8'h00;
   logic [2:0] v2 = 3'd0;
   logic       s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
   logic       m0 = 1'b0, m1 = 1'b0, m2 = 1'b0;
   logic [3:0] c0, c1;
   logic [1:0] c2;
   logic       f0, f1, f2, o0, o1, o2;

   cuenta_bits #(.N(8), .EARLY(1'b0)) u_n8 (
      .clk(clk), .reset(reset), .Valor(v0), .start(s0), .modo(m0),
      .Cuenta(c0), .fin(f0), .ocupado(o0));
   cuenta_bits #(.N(8), .EARLY(1'b1)) u_n8e (
      .clk(clk), .reset(reset), .Valor(v1), .start(s1), .modo(m1),
      .Cuenta(c1), .fin(f1), .ocupado(o1));
   cuenta_bits #(.N(3), .EARLY(1'b0)) u_n3 (
      .clk(clk), .reset(reset), .Valor(v2), .start(s2), .modo(m2),
      .Cuenta(c2), .fin(f2), .ocupado(o2));

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int cnt;
      int cyc;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   logic       fin_w [3];
   logic       ocu_w [3];
   logic [3:0] cnt_w [3];

   assign fin_w[0] = f0;
   assign fin_w[1] = f1;
   assign fin_w[2] = f2;
   assign ocu_w[0] = o0;
   assign ocu_w[1] = o1;
   assign ocu_w[2] = o2;
   assign cnt_w[0] = c0;
   assign cnt_w[1] = c1;
   assign cnt_w[2] = {2'b00, c2};

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: counts ocupado cycles per instance and checks each new result.
   initial begin
      int   run [3];
      logic fprev [3];
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         run[i]   = 0;
         fprev[i] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (ocu_w[i]) run[i]++;
            if (fin_w[i] && !fprev[i]) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_fin instance=%0d cuenta=%0d", i, cnt_w[i]);
               end else begin
                  e = sb_q.pop_front();
                  check("instance", i, e.id);
                  check("cuenta", int'(cnt_w[i]), e.cnt);
                  check("latency", run[i], e.cyc);
               end
            end
            if (!ocu_w[i]) run[i] = 0;
            fprev[i] = fin_w[i];
         end
      end
   end

   task automatic drive(input int id, input logic [7:0] val, input logic md, input logic st);
      case (id)
         0: begin v0 = val;      m0 = md; s0 = st; end
         1: begin v1 = val;      m1 = md; s1 = st; end
         default: begin v2 = val[2:0]; m2 = md; s2 = st; end
      endcase
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 50 && sb_q.size() != 0; c++) begin
         @(negedge clk);
         #1;
      end
      check("sb_drain", sb_q.size(), 0);
   endtask

   task automatic run_op(input int id, input logic [7:0] val, input logic md,
                         input int ecnt, input int ecyc, input bit disturb);
      @(negedge clk);
      sb_q.push_back('{id, ecnt, ecyc});
      drive(id, val, md, 1'b1);
      @(negedge clk);
      drive(id, val, md, 1'b0);
      if (disturb) begin
         drive(id, ~val, ~md, 1'b1);
         @(negedge clk);
         drive(id, val, md, 1'b0);
      end
      wait_drain();
   endtask

   initial begin
      int held;
      int fcount;
      logic [7:0] pc3 [8];
      pc3[0] = 8'd0; pc3[1] = 8'd1; pc3[2] = 8'd1; pc3[3] = 8'd2;
      pc3[4] = 8'd1; pc3[5] = 8'd2; pc3[6] = 8'd2; pc3[7] = 8'd3;

      #2 reset = 1'b1;
      #1;
      check("rst_cuenta0", int'(c0), 0);
      check("rst_fin0", int'(f0), 0);
      check("rst_ocupado0", int'(o0), 0);
      check("rst_fin1", int'(f1), 0);
      check("rst_fin2", int'(f2), 0);
      @(negedge clk);
      reset = 1'b0;

      // Basic ones count, then fin must hold with start low.
      run_op(0, 8'b1011_0010, 1'b0, 4, 8, 1'b0);
      held = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (f0 && !o0 && c0 == 4'd4) held++;
      end
      check("fin_hold", held, 20);

      // Zero-count mode, extremes.
      run_op(0, 8'h00, 1'b1, 8, 8, 1'b0);
      run_op(0, 8'hFF, 1'b1, 0, 8, 1'b0);

      // Early termination.
      run_op(1, 8'h00, 1'b0, 0, 1, 1'b0);
      run_op(1, 8'h01, 1'b0, 1, 1, 1'b0);
      run_op(1, 8'h80, 1'b0, 1, 8, 1'b0);
      run_op(1, 8'h0C, 1'b0, 2, 4, 1'b0);
      run_op(1, 8'hF0, 1'b1, 4, 4, 1'b0);

      // N=3 sweep; odd values also disturbed during SHIFT.
      for (int v = 0; v < 8; v++) begin
         logic [7:0] vv;
         vv = 8'(v);
         run_op(2, vv, 1'b0, int'(pc3[v]), 3, vv[0]);
      end

      // start held high, alternating operands: fin one cycle in every nine.
      for (int op = 0; op < 4; op++) sb_q.push_back('{0, 4, 8});
      fcount = 0;
      @(negedge clk);
      s0 = 1'b1;
      m0 = 1'b0;
      for (int op = 0; op < 4; op++) begin
         v0 = (op % 2 == 0) ? 8'hF0 : 8'h0F;
         for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            #1;
            if (f0) fcount++;
         end
      end
      s0 = 1'b0;
      check("fin_pulses", fcount, 4);
      wait_drain();

      // Asynchronous reset mid-SHIFT, after the third shift edge.
      @(negedge clk);
      drive(0, 8'hFF, 1'b0, 1'b1);
      @(negedge clk);
      drive(0, 8'hFF, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      check("mid_ocupado", int'(o0), 1);
      check("mid_cuenta", int'(c0), 3);
      reset = 1'b1;
      #1;
      check("arst_cuenta", int'(c0), 0);
      check("arst_fin", int'(f0), 0);
      check("arst_ocupado", int'(o0), 0);
      #2 reset = 1'b0;
      run_op(0, 8'h55, 1'b0, 4, 8, 1'b0);

      check("sb_final", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
